// File: rtl/mips_pkg.sv
// Opclass encoding and MIPS opcode/funct constants shared by the encoder and the decoders.
package mips_pkg;

    typedef enum logic [3:0] {
        OPC_ADD  = 4'd0,
        OPC_SUB  = 4'd1,
        OPC_AND  = 4'd2,
        OPC_OR   = 4'd3,
        OPC_SLT  = 4'd4,
        OPC_LW   = 4'd5,
        OPC_SW   = 4'd6,
        OPC_BEQ  = 4'd7,
        OPC_ADDI = 4'd8,
        OPC_J    = 4'd9,
        OPC_NOP  = 4'd10
    } opclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/sync_fifo.sv
// Register-based FIFO with synchronous clear; head word is visible on rdata while not empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] entries [DEPTH];
    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign rdata   = entries[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_q, entry_d;

        always_comb begin
            entry_d = entry_q;
            if (do_push && (wr_ptr_q[PW-1:0] == PW'(gi))) entry_d = wdata;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) entry_q <= '0;
            else          entry_q <= entry_d;
        end

        assign entries[gi] = entry_q;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instructions into MIPS words, buffers them and streams them into imem
// at consecutive word addresses.
module instr_encoder_loader
    import mips_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AW        = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_opc,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    output logic          imem_we,
    input  logic          imem_ready,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wd,
    output logic [AW:0]   count,
    output logic          err
);

    localparam logic [AW-1:0] BASE      = AW'(BASE_ADDR);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX   = '1;

    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          accept;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_rdata;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (in_opc)
            OPC_ADD:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_ADD};
            OPC_SUB:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SUB};
            OPC_AND:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_AND};
            OPC_OR:   enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_OR};
            OPC_SLT:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SLT};
            OPC_LW:   enc_word = {OP_LW,   in_rs, in_rt, in_imm};
            OPC_SW:   enc_word = {OP_SW,   in_rs, in_rt, in_imm};
            OPC_BEQ:  enc_word = {OP_BEQ,  in_rs, in_rt, in_imm};
            OPC_ADDI: enc_word = {OP_ADDI, in_rs, in_rt, in_imm};
            OPC_J:    enc_word = {OP_J, in_target};
            OPC_NOP:  enc_word = 32'h0;
            default:  enc_legal = 1'b0;
        endcase
    end

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign imem_we  = !fifo_empty;
    assign pop      = imem_we && imem_ready;

    // Illegal opclasses complete the handshake but never reach the FIFO.
    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start),
        .push    (accept && enc_legal),
        .pop     (pop),
        .wdata   (enc_word),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        if (start) begin
            addr_d  = BASE;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (pop) begin
                addr_d = addr_q + ADDR_ONE;
                if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
            end
            if (accept && !enc_legal) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign imem_addr = addr_q;
    assign imem_wd   = fifo_empty ? 32'h0 : fifo_rdata;
    assign count     = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and random stimulus against a queue-based reference model; two instances (AW=6, AW=2).
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_opc;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        imem_ready;

    logic        in_ready_a, imem_we_a, err_a;
    logic [5:0]  addr_a;
    logic [31:0] wd_a;
    logic [6:0]  count_a;

    logic        in_ready_b, imem_we_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wd_b;
    logic [2:0]  count_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];
    int unsigned m_addr6, m_addr2, m_cnt6, m_cnt2;
    bit m_err;

    instr_encoder_loader #(.DEPTH(DEPTH), .AW(6), .BASE_ADDR(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_opc(in_opc), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .imem_we(imem_we_a), .imem_ready(imem_ready), .imem_addr(addr_a),
        .imem_wd(wd_a), .count(count_a), .err(err_a)
    );

    instr_encoder_loader #(.DEPTH(DEPTH), .AW(2), .BASE_ADDR(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_opc(in_opc), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .imem_we(imem_we_b), .imem_ready(imem_ready), .imem_addr(addr_b),
        .imem_wd(wd_b), .count(count_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoding built from field positions with shifts.
    function automatic logic [31:0] encode(logic [3:0] opc, logic [4:0] rs, logic [4:0] rt,
                                           logic [4:0] rd, logic [15:0] imm, logic [25:0] tgt);
        logic [31:0] fn_tab [5];
        logic [31:0] op_tab [4];
        logic [31:0] regs;
        fn_tab = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        op_tab = '{32'h23, 32'h2B, 32'h04, 32'h08};
        regs = (32'(rs) << 21) | (32'(rt) << 16);
        if (opc <= 4'd4) return regs | (32'(rd) << 11) | fn_tab[opc];
        if (opc <= 4'd8) return (op_tab[opc - 4'd5] << 26) | regs | 32'(imm);
        if (opc == 4'd9) return (32'h2 << 26) | 32'(tgt);
        return 32'h0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_addr6 = 0; m_addr2 = 0; m_cnt6 = 0; m_cnt2 = 0; m_err = 0;
    endtask

    task automatic check_all(string tag);
        logic [31:0] exp_wd;
        exp_wd = (q.size() > 0) ? q[0] : 32'h0;
        chk({tag, ".in_ready_a"}, 32'(in_ready_a), 32'(q.size() < DEPTH));
        chk({tag, ".we_a"},       32'(imem_we_a),  32'(q.size() > 0));
        chk({tag, ".wd_a"},       wd_a,            exp_wd);
        chk({tag, ".addr_a"},     32'(addr_a),     m_addr6);
        chk({tag, ".count_a"},    32'(count_a),    m_cnt6);
        chk({tag, ".err_a"},      32'(err_a),      32'(m_err));
        chk({tag, ".we_b"},       32'(imem_we_b),  32'(q.size() > 0));
        chk({tag, ".wd_b"},       wd_b,            exp_wd);
        chk({tag, ".addr_b"},     32'(addr_b),     m_addr2);
        chk({tag, ".count_b"},    32'(count_b),    m_cnt2);
        chk({tag, ".err_b"},      32'(err_b),      32'(m_err));
    endtask

    // Check current outputs, then advance one clock and update the model.
    task automatic cycle(string tag);
        bit acc, popped;
        #1;
        check_all(tag);
        acc    = in_valid && (q.size() < DEPTH);
        popped = (q.size() > 0) && imem_ready;
        @(posedge clk);
        if (start) begin
            model_clear();
        end else begin
            if (popped) begin
                void'(q.pop_front());
                m_addr6 = (m_addr6 + 1) % 64;
                m_addr2 = (m_addr2 + 1) % 4;
                if (m_cnt6 < 127) m_cnt6++;
                if (m_cnt2 < 7)   m_cnt2++;
            end
            if (acc) begin
                if (in_opc <= 4'd10) q.push_back(encode(in_opc, in_rs, in_rt, in_rd, in_imm, in_target));
                else m_err = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(bit v, logic [3:0] opc, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                         logic [15:0] imm, logic [25:0] tgt);
        in_valid = v; in_opc = opc; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        cycle("start");
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] t2_words [4];
        t2_words = '{32'h20020005, 32'h8C020050, 32'h1085000A, 32'h08000011};
        reset_n = 1'b0; start = 1'b0; imem_ready = 1'b1;
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        model_clear();
        #2;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 1: single ADD
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF);
        cycle("t1_push");
        chk("t1_wd", wd_a, 32'h00221820);
        chk("t1_addr", 32'(addr_a), 32'h0);
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        cycle("t1_pop");
        chk("t1_count", 32'(count_a), 32'd1);

        // 2: back-to-back I/J types
        pulse_start();
        drive(1'b1, 4'd8, 5'd0, 5'd2, 5'd31, 16'h0005, 26'd0);  cycle("t2_0");
        chk("t2_wd0", wd_a, t2_words[0]); chk("t2_addr0", 32'(addr_a), 32'd0);
        drive(1'b1, 4'd5, 5'd0, 5'd2, 5'd0, 16'h0050, 26'd0);   cycle("t2_1");
        chk("t2_wd1", wd_a, t2_words[1]); chk("t2_addr1", 32'(addr_a), 32'd1);
        drive(1'b1, 4'd7, 5'd4, 5'd5, 5'd0, 16'h000A, 26'd0);   cycle("t2_2");
        chk("t2_wd2", wd_a, t2_words[2]); chk("t2_addr2", 32'(addr_a), 32'd2);
        drive(1'b1, 4'd9, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h11); cycle("t2_3");
        chk("t2_wd3", wd_a, t2_words[3]); chk("t2_addr3", 32'(addr_a), 32'd3);
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        cycle("t2_drain");

        // 3: stalled memory fills the FIFO, then drains in order
        pulse_start();
        imem_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1'b1, 4'd1, 5'(i), 5'(i + 1), 5'(i + 2), 16'd0, 26'd0);
            cycle("t3_fill");
        end
        chk("t3_full", 32'(in_ready_a), 32'd0);
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        imem_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle("t3_drain");
        chk("t3_count", 32'(count_a), DEPTH);

        // 4: address wrap on the AW=2 instance
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'd3, 5'(i), 5'd1, 5'd2, 16'd0, 26'd0);
            cycle("t4_push");
        end
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        cycle("t4_drain");
        cycle("t4_idle");
        chk("t4_count_b", 32'(count_b), 32'd6);
        chk("t4_addr_b", 32'(addr_b), 32'd2);

        // 5: illegal opclass sets err; start clears everything
        drive(1'b1, 4'hF, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1);
        cycle("t5_bad");
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        cycle("t5_idle");
        chk("t5_err", 32'(err_a), 32'd1);
        chk("t5_we", 32'(imem_we_a), 32'd0);
        pulse_start();
        #1;
        chk("t5_err_clr", 32'(err_a), 32'd0);
        chk("t5_addr_clr", 32'(addr_a), 32'd0);
        chk("t5_count_clr", 32'(count_a), 32'd0);

        // 6: asynchronous reset mid-burst
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd2, 5'd9, 5'd8, 5'd7, 16'd0, 26'd0);
            cycle("t6_fill");
        end
        imem_ready = 1'b1;
        cycle("t6_pop");
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_we", 32'(imem_we_a), 32'd0);
        chk("t6_addr", 32'(addr_a), 32'd0);
        chk("t6_count", 32'(count_a), 32'd0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        cycle("t6_after");

        // Random traffic, including starts and count saturation on the AW=2 instance
        for (int i = 0; i < 400; i++) begin
            logic [3:0] opc;
            opc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
            drive(1'($urandom_range(0, 3) != 0), opc, 5'($urandom), 5'($urandom), 5'($urandom),
                  16'($urandom), 26'($urandom));
            imem_ready = 1'($urandom_range(0, 3) != 0);
            start = 1'($urandom_range(0, 39) == 0);
            cycle("rand");
        end
        start = 1'b0;
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        imem_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle("final");
        check_all("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
